// File: rtl/mux_pipeline_arbiter.sv
// Round-robin, credit-gated arbiter driving mux_pipeline select, with a valid/select delay line matched to the mux latency.
// Optional packet locking (last port) is enabled by defining MUX_ARB_LOCK_EN.
module mux_pipeline_arbiter #(
    parameter int INPUT_COUNT = 4,
    parameter int MUX_LATENCY = 2,
    parameter int CREDITS     = 4,
    localparam int SEL_W      = $clog2(INPUT_COUNT),
    localparam int CNT_W      = $clog2(CREDITS + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [INPUT_COUNT-1:0]           req,
    output logic [INPUT_COUNT-1:0]           grant,
    output logic [SEL_W-1:0]                 sel,
    output logic                             sel_valid,
    output logic [(MUX_LATENCY+1)*SEL_W-1:0] sel_stage,
    output logic                             out_valid,
    output logic [SEL_W-1:0]                 out_sel,
    input  logic                             credit_return,
    output logic [CNT_W-1:0]                 credit_count,
    output logic                             credit_err
`ifdef MUX_ARB_LOCK_EN
   ,input  logic [INPUT_COUNT-1:0]           last
`endif
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_next;
    logic [SEL_W-1:0] scan_idx;
    logic             scan_hit;

    // Rotating priority scan; indices wrap at INPUT_COUNT, not at 2**SEL_W.
    always_comb begin
        int unsigned idx;
        scan_hit = 1'b0;
        scan_idx = '0;
        idx      = 0;
        for (int unsigned i = 0; i < INPUT_COUNT; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= INPUT_COUNT) idx = idx - INPUT_COUNT;
            if (!scan_hit && req[idx[SEL_W-1:0]]) begin
                scan_hit = 1'b1;
                scan_idx = idx[SEL_W-1:0];
            end
        end
    end

`ifdef MUX_ARB_LOCK_EN
    logic             locked;
    logic [SEL_W-1:0] lock_idx;
`endif

    always_comb begin
        grant = '0;
        sel   = '0;
        if (!rst && credit_count != '0) begin
`ifdef MUX_ARB_LOCK_EN
            if (locked) begin
                if (req[lock_idx]) begin
                    grant[lock_idx] = 1'b1;
                    sel             = lock_idx;
                end
            end else if (scan_hit) begin
                grant[scan_idx] = 1'b1;
                sel             = scan_idx;
            end
`else
            if (scan_hit) begin
                grant[scan_idx] = 1'b1;
                sel             = scan_idx;
            end
`endif
        end
    end

    assign sel_valid = |grant;
    assign ptr_next  = (sel == SEL_W'(INPUT_COUNT - 1)) ? '0 : sel + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr          <= '0;
            credit_count <= CNT_W'(CREDITS);
            credit_err   <= 1'b0;
        end else begin
            if (sel_valid) ptr <= ptr_next;
            case ({sel_valid, credit_return})
                2'b10: credit_count <= credit_count - 1'b1;
                2'b01: begin
                    if (credit_count == CNT_W'(CREDITS)) credit_err   <= 1'b1;
                    else                                 credit_count <= credit_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MUX_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            locked   <= 1'b0;
            lock_idx <= '0;
        end else if (sel_valid) begin
            if (locked) begin
                if (last[sel]) locked <= 1'b0;
            end else if (!last[sel]) begin
                locked   <= 1'b1;
                lock_idx <= sel;
            end
        end
    end
`endif

    generate
        if (MUX_LATENCY == 0) begin : g_comb
            assign sel_stage = sel;
            assign out_valid = sel_valid;
            assign out_sel   = sel;
        end else begin : g_pipe
            // Each entry is {valid, sel}; entry k-1 is delay stage k.
            logic [SEL_W:0] pipe [MUX_LATENCY];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned k = 0; k < MUX_LATENCY; k++) pipe[k] <= '0;
                end else begin
                    pipe[0] <= {sel_valid, sel};
                    for (int unsigned k = 1; k < MUX_LATENCY; k++) pipe[k] <= pipe[k-1];
                end
            end

            assign sel_stage[SEL_W-1:0] = sel;
            for (genvar k = 1; k <= MUX_LATENCY; k++) begin : g_slice
                assign sel_stage[k*SEL_W +: SEL_W] = pipe[k-1][SEL_W-1:0];
            end

            assign out_valid = pipe[MUX_LATENCY-1][SEL_W];
            assign out_sel   = pipe[MUX_LATENCY-1][SEL_W-1:0];
        end
    endgenerate

endmodule

// File: tb/tb_mux_pipeline_arbiter.sv
// Directed bench for mux_pipeline_arbiter with a reference model and an output scoreboard.
// Packet-lock scenario runs only when MUX_ARB_LOCK_EN is defined.
module tb_mux_pipeline_arbiter;

    localparam int IC  = 4;
    localparam int LAT = 2;
    localparam int CR  = 4;
`ifdef MUX_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       sel_valid;
    logic [5:0] sel_stage;
    logic       out_valid;
    logic [1:0] out_sel;
    logic       credit_return;
    logic [2:0] credit_count;
    logic       credit_err;
`ifdef MUX_ARB_LOCK_EN
    logic [3:0] last;
`endif

    always #5 clk = ~clk;

    mux_pipeline_arbiter #(
        .INPUT_COUNT (IC),
        .MUX_LATENCY (LAT),
        .CREDITS     (CR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .grant         (grant),
        .sel           (sel),
        .sel_valid     (sel_valid),
        .sel_stage     (sel_stage),
        .out_valid     (out_valid),
        .out_sel       (out_sel),
        .credit_return (credit_return),
        .credit_count  (credit_count),
        .credit_err    (credit_err)
`ifdef MUX_ARB_LOCK_EN
       ,.last          (last)
`endif
    );

    typedef struct {
        int unsigned due;
        logic [1:0]  s;
    } beat_t;

    beat_t       sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc   = 0;

    int unsigned m_ptr;
    int          m_cnt;
    logic        m_err;
    logic        m_lock;
    logic [1:0]  m_lidx;
    logic [1:0]  p1, p2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare against the model, advance the model.
    task automatic step(input logic [3:0] r, input logic cr, input logic rs, input logic [3:0] lst);
        logic [3:0] eg;
        logic [1:0] es;
        logic [1:0] k;
        bit         hit;
        req           = r;
        credit_return = cr;
        rst           = rs;
`ifdef MUX_ARB_LOCK_EN
        last          = lst;
`endif
        #1;
        eg  = '0;
        es  = '0;
        hit = 1'b0;
        if (!rs && m_cnt != 0) begin
            if (m_lock) begin
                if (r[m_lidx]) begin
                    hit = 1'b1;
                    es  = m_lidx;
                end
            end else begin
                for (int i = 0; i < IC; i++) begin
                    k = 2'((m_ptr + i) % IC);
                    if (!hit && r[k]) begin
                        hit = 1'b1;
                        es  = k;
                    end
                end
            end
        end
        if (hit) eg[es] = 1'b1;

        chk("grant", 32'(grant), 32'(eg));
        chk("sel", 32'(sel), 32'(es));
        chk("sel_valid", 32'(sel_valid), 32'(hit));
        chk("credit_count", 32'(credit_count), 32'(m_cnt));
        chk("credit_err", 32'(credit_err), 32'(m_err));
        chk("sel_stage", 32'(sel_stage), 32'({p2, p1, es}));
        if (sb.size() != 0 && sb[0].due == cyc) begin
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("out_sel", 32'(out_sel), 32'(sb[0].s));
            void'(sb.pop_front());
        end else begin
            chk("out_valid_idle", 32'(out_valid), 32'd0);
            chk("out_sel_idle", 32'(out_sel), 32'd0);
        end

        if (rs) begin
            m_ptr  = 0;
            m_cnt  = CR;
            m_err  = 1'b0;
            m_lock = 1'b0;
            p1     = '0;
            p2     = '0;
            sb.delete();
        end else begin
            if (hit) begin
                m_ptr = (32'(es) + 1) % IC;
                sb.push_back('{cyc + LAT, es});
                if (LOCK_EN) begin
                    if (m_lock) begin
                        if (lst[es]) m_lock = 1'b0;
                    end else if (!lst[es]) begin
                        m_lock = 1'b1;
                        m_lidx = es;
                    end
                end
            end
            if (hit && !cr) m_cnt--;
            else if (!hit && cr) begin
                if (m_cnt == CR) m_err = 1'b1;
                else             m_cnt++;
            end
            p2 = p1;
            p1 = es;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst           = 1'b1;
        req           = 4'hF;
        credit_return = 1'b0;
`ifdef MUX_ARB_LOCK_EN
        last          = 4'hF;
`endif
        m_ptr  = 0;
        m_cnt  = CR;
        m_err  = 1'b0;
        m_lock = 1'b0;
        m_lidx = '0;
        p1     = '0;
        p2     = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state with all requesters active
        chk("rst_count", 32'(credit_count), CR);
        chk("rst_err", 32'(credit_err), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_sel_stage", 32'(sel_stage), 0);
        step(4'hF, 1'b0, 1'b1, 4'hF);

        // T1: full load with a credit returned every cycle
        step(4'hF, 1'b0, 1'b0, 4'hF);
        repeat (7) step(4'hF, 1'b1, 1'b0, 4'hF);
        chk("t1_count", 32'(credit_count), 3);
        step(4'h0, 1'b1, 1'b0, 4'hF);
        repeat (2) step(4'h0, 1'b0, 1'b0, 4'hF);

        // T2: credit exhaustion, then a single returned credit
        repeat (4) step(4'hF, 1'b0, 1'b0, 4'hF);
        chk("t2_count0", 32'(credit_count), 0);
        step(4'hF, 1'b0, 1'b0, 4'hF);
        step(4'hF, 1'b1, 1'b0, 4'hF);
        req = 4'hF; credit_return = 1'b0; #1;
        chk("t2_one_grant", 32'(grant), 32'h1);
        step(4'hF, 1'b0, 1'b0, 4'hF);
        step(4'hF, 1'b0, 1'b0, 4'hF);
        repeat (4) step(4'h0, 1'b1, 1'b0, 4'hF);
        chk("t2_refill", 32'(credit_count), 4);

        // T3: pointer advance and wrap
        step(4'b0001, 1'b0, 1'b0, 4'hF);
        req = 4'b0100; credit_return = 1'b0; #1;
        chk("t3_grant", 32'(grant), 32'b0100);
        chk("t3_sel", 32'(sel), 2);
        step(4'b0100, 1'b0, 1'b0, 4'hF);
        req = 4'b1010; #1;
        chk("t3_ptr3", 32'(sel), 3);
        step(4'b1010, 1'b0, 1'b0, 4'hF);
        req = 4'b0001; #1;
        chk("t3_wrap", 32'(grant), 32'b0001);
        step(4'b0001, 1'b0, 1'b0, 4'hF);
        repeat (2) step(4'h0, 1'b1, 1'b0, 4'hF);

        // T4: simultaneous grant/return, then overflow at full credits
        chk("t4_count2", 32'(credit_count), 2);
        step(4'b0001, 1'b1, 1'b0, 4'hF);
        chk("t4_same_cycle", 32'(credit_count), 2);
        repeat (2) step(4'h0, 1'b1, 1'b0, 4'hF);
        chk("t4_full_no_err", 32'(credit_err), 0);
        step(4'h0, 1'b1, 1'b0, 4'hF);
        chk("t4_overflow_count", 32'(credit_count), 4);
        chk("t4_err", 32'(credit_err), 1);
        step(4'h0, 1'b0, 1'b0, 4'hF);
        chk("t4_err_sticky", 32'(credit_err), 1);

        // T5: reset with beats in flight
        repeat (2) step(4'hF, 1'b0, 1'b0, 4'hF);
        step(4'hF, 1'b0, 1'b1, 4'hF);
        chk("t5_out_valid", 32'(out_valid), 0);
        chk("t5_count", 32'(credit_count), 4);
        chk("t5_err_clr", 32'(credit_err), 0);
        rst = 1'b0; req = 4'b0110; credit_return = 1'b0; #1;
        chk("t5_first_grant", 32'(sel), 1);
        step(4'b0110, 1'b0, 1'b0, 4'hF);
        repeat (3) step(4'h0, 1'b0, 1'b0, 4'hF);

`ifdef MUX_ARB_LOCK_EN
        // T6: input 0 holds the grant for a 3-beat packet
        step(4'h0, 1'b0, 1'b1, 4'hF);
        rst = 1'b0; req = 4'b0011; last = 4'b1110; credit_return = 1'b0; #1;
        chk("t6_beat0", 32'(sel), 0);
        step(4'b0011, 1'b0, 1'b0, 4'b1110);
        req = 4'b0010; #1;
        chk("t6_locked_idle", 32'(grant), 0);
        step(4'b0010, 1'b1, 1'b0, 4'b1110);
        req = 4'b0011; #1;
        chk("t6_beat1", 32'(sel), 0);
        step(4'b0011, 1'b0, 1'b0, 4'b1110);
        last = 4'b1111; #1;
        chk("t6_beat2", 32'(sel), 0);
        step(4'b0011, 1'b0, 1'b0, 4'b1111);
        #1;
        chk("t6_unlock", 32'(sel), 1);
        step(4'b0011, 1'b0, 1'b0, 4'b1111);
        repeat (3) step(4'h0, 1'b0, 1'b0, 4'hF);
`endif

        chk("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
